gpu_mode_ctrl: RTL
==================

GPU_MODE_CTRL -- requirements
Module: gpu_mode_ctrl

Interface
REQ-001 SHALL provide parameter BLANK_FRAMES, default 1, giving the number of full frames of forced black after a mode switch when blanking is enabled (legal range 1..15).
REQ-002 SHALL use a single clock; reset is asynchronous and active-low.
REQ-003 SHALL provide these ports:
- clk  in  1  pixel/system clock
- rst_n  in  1  asynchronous active-low reset
- reg_we  in  1  register write strobe, one cycle
- reg_re  in  1  register read strobe, one cycle
- reg_addr  in  2  register select
- reg_wdata  in  8  write data
- reg_rdata  out  8  read data
- vsync  in  1  vertical sync, active-high, synchronous to clk
- display_mode  out  1  to the RGB mux select (0=character, 1=graphics)
- blank_out  out  1  force-black request to the output stage
- mode_pending  out  1  switch requested but not yet applied
- irq  out  1  switch-complete interrupt, level

Function
REQ-004 SHALL decode the register map as follows:
- addr 0 MODE_REQ: bit0 is the requested mode (R/W).
- addr 1 STATUS (read-only except W1C): bit0 display_mode; bit1 pending; bit2 done flag, cleared by writing 1 to bit2.
- addr 2 CTRL (R/W): bit0 irq_en; bit1 blank_en.
- addr 3: reads 0x00; writes ignored.
- Unused bits read 0.
REQ-005 SHALL register reg_rdata, valid on the cycle after reg_re, and SHALL hold the previous value when reg_re is low.
REQ-006 SHALL detect a frame boundary as a vsync rising edge (vsync=1, previous sample=0), costing one register of delay.
REQ-007 SHALL implement the FSM states IDLE, WAIT_VS and BLANK.
REQ-008 IDLE: when req_mode != display_mode, SHALL go to WAIT_VS and assert mode_pending the next cycle.
REQ-009 WAIT_VS: if req_mode == display_mode (request cancelled), SHALL return to IDLE with no switch and no done flag.
REQ-010 WAIT_VS, on a frame boundary: display_mode SHALL take req_mode in the same cycle as the state transition. If blank_en=1, the next state is BLANK with frame counter = BLANK_FRAMES. Otherwise the next state is IDLE and the done flag is set.
REQ-011 BLANK: blank_out SHALL be 1; each frame boundary decrements the counter; when the counter reaches 0, SHALL go to IDLE, deassert blank_out and set the done flag.
REQ-012 In BLANK, a new differing request SHALL be held and SHALL be taken from IDLE on the following cycle, so the next switch waits for a fresh boundary.
REQ-013 A MODE_REQ write in the same cycle as a frame boundary SHALL NOT affect that boundary's decision; the switch uses the req_mode registered before that cycle.
REQ-014 mode_pending SHALL be 1 exactly when the state is WAIT_VS.
REQ-015 irq SHALL equal done flag AND irq_en.
REQ-016 A done-flag W1C write in the same cycle as a set event SHALL leave the flag set (set wins).
REQ-017 display_mode SHALL change only on frame boundaries; a CPU write never toggles it directly.

Reset
REQ-018 On rst_n low, asynchronously:
- state IDLE
- req_mode=0, display_mode=0
- blank_out=0, mode_pending=0
- done flag=0, irq_en=0, blank_en=0
- counter=0, reg_rdata=0x00
- edge-detect history=0, so a vsync held high during reset release is not a boundary
REQ-019 Reset asserted mid-switch (WAIT_VS or BLANK) SHALL abort the switch with no done flag after release.

Verification
REQ-020 The bench SHALL cover:
- Write MODE_REQ=1, blank_en=0, pulse vsync: mode_pending=1 until the edge; display_mode=1 one cycle after the registered edge; STATUS reads 0x05.
- blank_en=1, BLANK_FRAMES=2, request mode 1: display_mode=1 at the first boundary; blank_out=1 for exactly two further boundaries; then done=1, and irq=1 only if irq_en=1.
- Write 1 then 0 to MODE_REQ before vsync: returns to IDLE, display_mode stays 0, done=0, no irq.
- Write MODE_REQ on the vsync edge cycle: switch uses the prior value; the new request is serviced at the next boundary.
- Write STATUS=0x04 on the cycle the done flag sets: flag remains 1. A later write of 0x04 clears it and irq drops.
- Assert rst_n low during BLANK: all outputs go 0 immediately; no irq after release.

Source files
------------

// File: rtl/gpu_mode_ctrl.sv
// Display mode controller: CPU-requested character/graphics switches are applied
// only on a vsync rising edge, optionally followed by forced-black frames.
module gpu_mode_ctrl #(
  parameter int BLANK_FRAMES = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       reg_we,
  input  logic       reg_re,
  input  logic [1:0] reg_addr,
  input  logic [7:0] reg_wdata,
  output logic [7:0] reg_rdata,
  input  logic       vsync,
  output logic       display_mode,
  output logic       blank_out,
  output logic       mode_pending,
  output logic       irq
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_VS = 2'd1,
    BLANK   = 2'd2
  } state_t;

  state_t      state_r, state_n;
  logic [3:0]  cnt_r, cnt_n;
  logic        req_mode_r, req_mode_n;
  logic        display_mode_r, display_mode_n;
  logic        done_r, done_n;
  logic        irq_en_r, irq_en_n;
  logic        blank_en_r, blank_en_n;
  logic        blank_out_r, mode_pending_r, irq_r;
  logic [7:0]  rdata_r, rdata_n;
  logic        vsync_q_r;
  logic        hist_valid_r;
  logic        edge_s;
  logic        done_set_s;
  logic        w1c_s;

  // The first sample after reset only primes the history, so a vsync
  // already high at release is not taken as a boundary.
  assign edge_s = vsync & ~vsync_q_r & hist_valid_r;
  assign w1c_s  = reg_we & (reg_addr == 2'd1) & reg_wdata[2];

  // Mode-switch FSM next state, counter and display mode.
  always_comb begin
    state_n        = state_r;
    cnt_n          = cnt_r;
    display_mode_n = display_mode_r;
    done_set_s     = 1'b0;
    case (state_r)
      IDLE: begin
        if (req_mode_r != display_mode_r) state_n = WAIT_VS;
        else                              state_n = IDLE;
      end
      WAIT_VS: begin
        if (req_mode_r == display_mode_r) begin
          state_n = IDLE;
        end else if (edge_s) begin
          display_mode_n = req_mode_r;
          if (blank_en_r) begin
            state_n = BLANK;
            cnt_n   = 4'(BLANK_FRAMES);
          end else begin
            state_n    = IDLE;
            done_set_s = 1'b1;
          end
        end else begin
          state_n = WAIT_VS;
        end
      end
      BLANK: begin
        if (edge_s) begin
          if (cnt_r <= 4'd1) begin
            state_n    = IDLE;
            cnt_n      = 4'd0;
            done_set_s = 1'b1;
          end else begin
            cnt_n = cnt_r - 4'd1;
          end
        end else begin
          state_n = BLANK;
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = 4'd0;
      end
    endcase
  end

  // Register file writes and the registered read mux.
  always_comb begin
    req_mode_n = (reg_we && reg_addr == 2'd0) ? reg_wdata[0] : req_mode_r;
    irq_en_n   = (reg_we && reg_addr == 2'd2) ? reg_wdata[0] : irq_en_r;
    blank_en_n = (reg_we && reg_addr == 2'd2) ? reg_wdata[1] : blank_en_r;
    // A set event in the same cycle as the clear keeps the flag set.
    done_n     = done_set_s ? 1'b1 : (w1c_s ? 1'b0 : done_r);
    rdata_n    = rdata_r;
    if (reg_re) begin
      case (reg_addr)
        2'd0:    rdata_n = {7'd0, req_mode_r};
        2'd1:    rdata_n = {5'd0, done_r, mode_pending_r, display_mode_r};
        2'd2:    rdata_n = {6'd0, blank_en_r, irq_en_r};
        default: rdata_n = 8'h00;
      endcase
    end else begin
      rdata_n = rdata_r;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r        <= IDLE;
      cnt_r          <= 4'd0;
      req_mode_r     <= 1'b0;
      display_mode_r <= 1'b0;
      done_r         <= 1'b0;
      irq_en_r       <= 1'b0;
      blank_en_r     <= 1'b0;
      blank_out_r    <= 1'b0;
      mode_pending_r <= 1'b0;
      irq_r          <= 1'b0;
      rdata_r        <= 8'h00;
      vsync_q_r      <= 1'b0;
      hist_valid_r   <= 1'b0;
    end else begin
      state_r        <= state_n;
      cnt_r          <= cnt_n;
      req_mode_r     <= req_mode_n;
      display_mode_r <= display_mode_n;
      done_r         <= done_n;
      irq_en_r       <= irq_en_n;
      blank_en_r     <= blank_en_n;
      blank_out_r    <= (state_n == BLANK);
      mode_pending_r <= (state_n == WAIT_VS);
      irq_r          <= done_n & irq_en_n;
      rdata_r        <= rdata_n;
      vsync_q_r      <= vsync;
      hist_valid_r   <= 1'b1;
    end
  end

  assign reg_rdata    = rdata_r;
  assign display_mode = display_mode_r;
  assign blank_out    = blank_out_r;
  assign mode_pending = mode_pending_r;
  assign irq          = irq_r;

endmodule
